// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with an output register, a one-entry
// skid buffer and a saturating illegal-encoding counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_NONE  = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I     = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S     = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B     = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U     = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J     = 3'd5;
  localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } bundle_t;

  bundle_t    dec_c;
  bundle_t    out_q;
  bundle_t    skid_q;
  logic       skid_full;
  logic [6:0] opcode_c;
  logic [2:0] funct3_c;
  logic       accept_c;
  logic       load_out_c;

  assign opcode_c   = in_instr[6:0];
  assign funct3_c   = in_instr[14:12];
  assign accept_c   = in_valid && in_ready;
  assign load_out_c = !out_valid || out_ready;

  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

  // Immediate decode of the word currently on the input.
  always_comb begin
    dec_c = '0;
    case (opcode_c)
      OP_IMM: begin
        if (funct3_c == 3'b001 || funct3_c == 3'b101) begin
          dec_c.fmt = FMT_SHAMT;
          if (XLEN == 32) begin
            dec_c.imm = XLEN'(in_instr[24:20]);
            if (in_instr[25]) dec_c.illegal = 1'b1;
          end else begin
            dec_c.imm = XLEN'(in_instr[25:20]);
          end
          if (funct3_c == 3'b101 && in_instr[31:26] != 6'b000000
              && in_instr[31:26] != 6'b010000)
            dec_c.illegal = 1'b1;
        end else begin
          dec_c.fmt = FMT_I;
          dec_c.imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_c.fmt = FMT_I;
        dec_c.imm = XLEN'($signed(in_instr[31:20]));
      end
      OP_STORE: begin
        dec_c.fmt = FMT_S;
        dec_c.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        dec_c.fmt = FMT_B;
        dec_c.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                    in_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_c.fmt = FMT_U;
        dec_c.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec_c.fmt = FMT_J;
        dec_c.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                    in_instr[30:21], 1'b0}));
      end
      OP_REG: begin
        dec_c.fmt = FMT_NONE;
      end
      default: begin
        dec_c.fmt     = FMT_NONE;
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  // Output register with skid entry; in_ready only depends on skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      in_ready  <= 1'b1;
    end else if (load_out_c) begin
      if (skid_full) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        out_valid <= accept_c;
        if (accept_c) out_q <= dec_c;
      end
    end else if (accept_c) begin
      skid_q    <= dec_c;
      skid_full <= 1'b1;
      in_ready  <= 1'b0;
    end
  end

  // Saturating illegal counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      illegal_cnt <= '0;
    end else if (accept_c && dec_c.illegal && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN32/CNT_W=2 and an XLEN64/CNT_W=16 instance share
// one input stream and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;
  logic        cnt_clr;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  int          mcnt32 = 0;
  int          mcnt64 = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32),
    .illegal_cnt(cnt32), .cnt_clr(cnt_clr));

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64),
    .illegal_cnt(cnt64), .cnt_clr(cnt_clr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint x, input int n);
    longint one = 1;
    return (x >= (one << (n - 1))) ? x - (one << n) : x;
  endfunction

  // Reference decode from the architectural immediate rules.
  function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint v = 0;
    logic [63:0] e;
    fmt = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'h13: begin
        if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
          fmt = 3'd6;
          v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
          if (xlen == 32 && ins[25]) ill = 1'b1;
          if (ins[14:12] == 3'd5 && ins[31:26] != 6'd0 && ins[31:26] != 6'd16) ill = 1'b1;
        end else begin
          fmt = 3'd1;
          v = sx(longint'(ins[31:20]), 12);
        end
      end
      7'h03, 7'h67: begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
      7'h23: begin fmt = 3'd2; v = sx(longint'({ins[31:25], ins[11:7]}), 12); end
      7'h63: begin
        fmt = 3'd3;
        v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
      end
      7'h37, 7'h17: begin fmt = 3'd4; v = sx(longint'(ins[31:12]), 20) * 4096; end
      7'h6F: begin
        fmt = 3'd5;
        v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
      end
      7'h33: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
    e = v;
    imm = (xlen == 32) ? {32'h0, e[31:0]} : e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 11))
      0: r[6:0] = 7'h13;
      1: begin
        r[6:0] = 7'h13;
        r[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
        case ($urandom_range(0, 2))
          0: r[31:26] = 6'd0;
          1: r[31:26] = 6'd16;
          default: ;
        endcase
      end
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h23;
      5: r[6:0] = 7'h63;
      6: r[6:0] = 7'h37;
      7: r[6:0] = 7'h17;
      8: r[6:0] = 7'h6F;
      9: r[6:0] = 7'h33;
      default: ;
    endcase
    return r;
  endfunction

  // Check visible state, then advance one clock and update the model.
  task automatic tick(output bit acc);
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    logic [31:0] ins;
    bit          pop;
    bit          clr;
    chk("valid32", 64'(vld32), 64'(q.size() != 0));
    chk("valid64", 64'(vld64), 64'(q.size() != 0));
    chk("ready32", 64'(rdy32), 64'(q.size() < 2));
    chk("ready64", 64'(rdy64), 64'(q.size() < 2));
    chk("cnt32", 64'(cnt32), 64'(mcnt32));
    chk("cnt64", 64'(cnt64), 64'(mcnt64));
    if (q.size() != 0) begin
      ref_dec(q[0], 32, e_imm, e_fmt, e_ill);
      chk("imm32", 64'(imm32), e_imm);
      chk("fmt32", 64'(fmt32), 64'(e_fmt));
      chk("ill32", 64'(ill32), 64'(e_ill));
      ref_dec(q[0], 64, e_imm, e_fmt, e_ill);
      chk("imm64", imm64, e_imm);
      chk("fmt64", 64'(fmt64), 64'(e_fmt));
      chk("ill64", 64'(ill64), 64'(e_ill));
    end
    acc = in_valid && (q.size() < 2);
    pop = out_ready && (q.size() != 0);
    ins = in_instr;
    clr = cnt_clr;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(ins);
    if (clr) begin
      mcnt32 = 0;
      mcnt64 = 0;
    end else if (acc) begin
      ref_dec(ins, 32, e_imm, e_fmt, e_ill);
      if (e_ill && mcnt32 < 3) mcnt32++;
      ref_dec(ins, 64, e_imm, e_fmt, e_ill);
      if (e_ill && mcnt64 < 65535) mcnt64++;
    end
  endtask

  task automatic send1(input logic [31:0] ins);
    bit a;
    in_valid = 1'b1;
    in_instr = ins;
    tick(a);
    in_valid = 1'b0;
    chk("send_accepted", 64'(a), 64'd1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  initial begin
    bit a;
    bit pend;
    bit done;
    logic [31:0] cur;
    logic [31:0] bp[3];

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid32", 64'(vld32), 64'd0);
    chk("rst_ready32", 64'(rdy32), 64'd1);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_fmt64", 64'(fmt64), 64'd0);
    chk("rst_ill32", 64'(ill32), 64'd0);
    chk("rst_cnt32", 64'(cnt32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed formats with a free-running consumer.
    out_ready = 1'b1;
    send1(32'hFFF00093);
    chk("addi_imm", 64'(imm32), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(fmt32), 64'd1);
    send1(32'h4030D093);
    chk("srai_imm", 64'(imm32), 64'h3);
    chk("srai_fmt", 64'(fmt32), 64'd6);
    send1(32'h0200D093);
    chk("shamt25_ill32", 64'(ill32), 64'd1);
    chk("shamt25_cnt32", 64'(cnt32), 64'd1);
    send1(32'hFE000EE3);
    chk("beq_imm", 64'(imm32), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(fmt32), 64'd3);
    send1(32'h001000EF);
    chk("jal_imm", 64'(imm32), 64'h800);
    chk("jal_fmt", 64'(fmt32), 64'd5);
    send1(32'h800000B7);
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", 64'(fmt64), 64'd4);
    idle(2);

    // Backpressure: third word must be held off until the skid drains.
    bp[0] = 32'h00A00113; bp[1] = 32'h00112423; bp[2] = 32'h123450B7;
    out_ready = 1'b0;
    send1(bp[0]);
    send1(bp[1]);
    chk("bp_ready_low", 64'(rdy32), 64'd0);
    in_valid = 1'b1;
    in_instr = bp[2];
    tick(a);
    chk("bp_third_held", 64'(a), 64'd0);
    tick(a);
    chk("bp_first_stable", 64'(imm32), 64'hA);
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 6 && !done; i++) begin
      tick(a);
      if (a) done = 1'b1;
    end
    in_valid = 1'b0;
    chk("bp_third_accepted", 64'(done), 64'd1);
    idle(4);

    // Randomised traffic with upstream hold and random backpressure.
    pend = 1'b0;
    cur = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        cur = gen_instr();
        pend = 1'b1;
      end
      in_valid = pend;
      in_instr = cur;
      out_ready = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      cnt_clr = ($urandom_range(0, 40) == 0);
      tick(a);
      if (a) pend = 1'b0;
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Counter saturation and clear priority.
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send1(32'h0000007F);
    chk("sat_cnt32", 64'(cnt32), 64'd3);
    chk("sat_cnt64", 64'(cnt64), 64'd5);
    chk("illop_imm", 64'(imm32), 64'd0);
    cnt_clr = 1'b1;
    send1(32'h0000007F);
    cnt_clr = 1'b0;
    chk("clr_prio_cnt32", 64'(cnt32), 64'd0);
    chk("clr_prio_cnt64", 64'(cnt64), 64'd0);
    idle(2);

    // Asynchronous reset with two bundles in flight.
    out_ready = 1'b0;
    send1(32'h00500093);
    send1(32'hFFC00083);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid32", 64'(vld32), 64'd0);
    chk("midrst_valid64", 64'(vld64), 64'd0);
    chk("midrst_ready32", 64'(rdy32), 64'd1);
    chk("midrst_imm32", 64'(imm32), 64'd0);
    q.delete();
    mcnt32 = 0;
    mcnt64 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send1(32'h00C00067);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
